// File: rtl/shift_decrypt.sv
// rtl/shift_decrypt.sv - shift-cipher decryptor with per-frame key latch and 2-stage elastic output pipeline
module shift_decrypt #(
   parameter int N     = 8,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             en,
   input  logic [N-1:0]     din,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [4:0]       shift_num,
   input  logic [1:0]       direction,
   output logic [N-1:0]     dout,
   output logic             v,
   input  logic             out_ready,
   output logic             out_last,
   output logic [CNT_W-1:0] byte_cnt,
   output logic             key_err
);

   typedef enum logic [1:0] {
      CL_OTHER = 2'd0,
      CL_UPPER = 2'd1,
      CL_LOWER = 2'd2
   } cls_t;

   localparam logic [1:0] MODE_FWD = 2'b10;
   localparam logic [1:0] MODE_BWD = 2'b01;

   // S1 registers
   logic         s1_v;
   logic [N-1:0] s1_data;
   logic         s1_last;
   logic [4:0]   s1_key;
   logic [1:0]   s1_mode;
   cls_t         s1_cls;

   // S2 is the output register
   logic         s2_v;

   // frame state
   logic [4:0]   k_l;
   logic [1:0]   d_l;
   logic         first;

   logic         s2_load;
   logic         s1_adv;
   logic         accept;
   logic         xfer;
   logic [4:0]   key_red;
   logic [4:0]   eff_key;
   logic [1:0]   eff_mode;
   cls_t         din_cls;
   logic         key_mismatch;

   logic [4:0]   o;
   logic [4:0]   kc;
   logic [4:0]   t;
   logic [N-1:0] plain;

   function automatic cls_t classify(input logic [N-1:0] c);
      if (c >= 8'h41 && c <= 8'h5A)
         return CL_UPPER;
      else if (c >= 8'h61 && c <= 8'h7A)
         return CL_LOWER;
      else
         return CL_OTHER;
   endfunction

   always_comb begin
      s2_load  = !s2_v || out_ready;
      s1_adv   = !s1_v || s2_load;
      in_ready = en && !rst && s1_adv;
      accept   = in_valid && in_ready;
      xfer     = s2_v && out_ready;
      v        = s2_v;
   end

   always_comb begin
      key_red      = (shift_num >= 5'd26) ? shift_num - 5'd26 : shift_num;
      eff_key      = first ? key_red : k_l;
      eff_mode     = first ? direction : d_l;
      din_cls      = classify(din);
      key_mismatch = !first && ((key_red != k_l) || (direction != d_l));
   end

   // Letters in both cases have low five bits 1..26, so offset o is those bits minus one
   // and the upper three bits carry the case through untouched.
   always_comb begin
      o     = s1_data[4:0] - 5'd1;
      kc    = 5'd26 - s1_key;
      t     = o;
      plain = s1_data;
      if (s1_cls != CL_OTHER && s1_key != 5'd0) begin
         if (s1_mode == MODE_FWD) begin
            t     = (o >= s1_key) ? o - s1_key : o + kc;
            plain = {s1_data[N-1:5], t + 5'd1};
         end else if (s1_mode == MODE_BWD) begin
            t     = (o >= kc) ? o - kc : o + s1_key;
            plain = {s1_data[N-1:5], t + 5'd1};
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         k_l     <= '0;
         d_l     <= '0;
         first   <= 1'b1;
         key_err <= 1'b0;
      end else begin
         key_err <= accept && key_mismatch;
         if (accept) begin
            first <= in_last;
            if (first) begin
               k_l <= key_red;
               d_l <= direction;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         s1_v    <= 1'b0;
         s1_data <= '0;
         s1_last <= 1'b0;
         s1_key  <= '0;
         s1_mode <= '0;
         s1_cls  <= CL_OTHER;
      end else if (s1_adv) begin
         s1_v <= accept;
         if (accept) begin
            s1_data <= din;
            s1_last <= in_last;
            s1_key  <= eff_key;
            s1_mode <= eff_mode;
            s1_cls  <= din_cls;
         end
      end
   end

   // dout/out_last only move when a new byte enters S2, so they stay stable under backpressure
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         s2_v     <= 1'b0;
         dout     <= '0;
         out_last <= 1'b0;
      end else if (s2_load) begin
         s2_v <= s1_v;
         if (s1_v) begin
            dout     <= plain;
            out_last <= s1_last;
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst)
         byte_cnt <= '0;
      else if (xfer && byte_cnt != {CNT_W{1'b1}})
         byte_cnt <= byte_cnt + 1'b1;
   end

endmodule

// File: tb/tb_shift_decrypt.sv
// tb/tb_shift_decrypt.sv - scoreboard bench for shift_decrypt
module tb_shift_decrypt;

   logic        clock;
   logic        rst;
   logic        en;
   logic [7:0]  din;
   logic        in_valid;
   logic        in_ready;
   logic        in_last;
   logic [4:0]  shift_num;
   logic [1:0]  direction;
   logic [7:0]  dout;
   logic        v;
   logic        out_ready;
   logic        out_last;
   logic [15:0] byte_cnt;
   logic        key_err;

   int checks = 0;
   int errors = 0;
   int kerr_cnt = 0;
   logic [8:0] sb[$];

   shift_decrypt #(.N(8), .CNT_W(16)) dut (
      .clock(clock), .rst(rst), .en(en), .din(din), .in_valid(in_valid),
      .in_ready(in_ready), .in_last(in_last), .shift_num(shift_num),
      .direction(direction), .dout(dout), .v(v), .out_ready(out_ready),
      .out_last(out_last), .byte_cnt(byte_cnt), .key_err(key_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: pops expected byte on every output transfer
   always @(negedge clock) begin
      if (!rst && v && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got 0x%0h expected no output", dout);
         end else begin
            logic [8:0] e;
            e = sb.pop_front();
            chk("dout", {24'h0, dout}, {24'h0, e[7:0]});
            chk("out_last", {31'h0, out_last}, {31'h0, e[8]});
         end
      end
      if (key_err) kerr_cnt++;
   end

   task automatic send(input logic [7:0] d, input logic l, input logic [4:0] sn,
                       input logic [1:0] dir, input logic [7:0] exp);
      bit ok;
      sb.push_back({l, exp});
      din = d; in_last = l; shift_num = sn; direction = dir; in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clock);
         ok = in_ready;
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1");
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clock);
      repeat (2) @(posedge clock);
      #1;
      chk("drained", sb.size(), 0);
   endtask

   logic [7:0] bp_in [4];
   logic [7:0] bp_exp[4];
   int idx, accepts, kbase;
   bit acc;

   initial begin
      rst = 1'b1; en = 1'b1; din = '0; in_valid = 1'b0; in_last = 1'b0;
      shift_num = '0; direction = '0; out_ready = 1'b1;
      #2;
      chk("rst_v", {31'h0, v}, 0);
      chk("rst_dout", {24'h0, dout}, 0);
      chk("rst_out_last", {31'h0, out_last}, 0);
      chk("rst_byte_cnt", {16'h0, byte_cnt}, 0);
      chk("rst_key_err", {31'h0, key_err}, 0);
      chk("rst_in_ready", {31'h0, in_ready}, 0);
      @(posedge clock); #1; rst = 1'b0;
      @(posedge clock); #1;

      // forward-shifted frame "F","a", key 5
      send(8'h46, 1'b0, 5'd5, 2'b10, 8'h41);
      chk("lat_v_after_1", {31'h0, v}, 0);
      send(8'h61, 1'b1, 5'd5, 2'b10, 8'h76);
      chk("lat_v_after_2", {31'h0, v}, 1);
      drain();
      chk("byte_cnt_2", {16'h0, byte_cnt}, 2);

      // backward-shifted, key 3 and its alias 29
      send(8'h78, 1'b1, 5'd3, 2'b01, 8'h61);
      send(8'h78, 1'b1, 5'd29, 2'b01, 8'h61);
      // pass-through cases
      send(8'h51, 1'b1, 5'd26, 2'b10, 8'h51);
      send(8'h0B, 1'b1, 5'd5, 2'b10, 8'h0B);
      send(8'h46, 1'b1, 5'd5, 2'b00, 8'h46);
      drain();
      chk("byte_cnt_7", {16'h0, byte_cnt}, 7);

      // backpressure: "BCDE" key 1 forward -> "ABCD"
      bp_in  = '{8'h42, 8'h43, 8'h44, 8'h45};
      bp_exp = '{8'h41, 8'h42, 8'h43, 8'h44};
      out_ready = 1'b0;
      idx = 0; accepts = 0;
      sb.push_back({1'b0, bp_exp[0]});
      din = bp_in[0]; in_last = 1'b0; shift_num = 5'd1; direction = 2'b10; in_valid = 1'b1;
      for (int c = 0; c < 40 && idx < 4; c++) begin
         if (c == 2) chk("bp_dout_early", {24'h0, dout}, 8'h41);
         if (c == 5) begin
            chk("bp_accepts", accepts, 2);
            chk("bp_in_ready", {31'h0, in_ready}, 0);
            chk("bp_v", {31'h0, v}, 1);
            chk("bp_dout_stable", {24'h0, dout}, 8'h41);
            out_ready = 1'b1;
         end
         @(negedge clock);
         acc = in_ready && in_valid;
         @(posedge clock);
         #1;
         if (acc) begin
            accepts++;
            idx++;
            if (idx < 4) begin
               sb.push_back({idx == 3, bp_exp[idx]});
               din = bp_in[idx];
               in_last = (idx == 3);
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      chk("bp_total", accepts, 4);
      drain();

      // mid-frame key change: 5 -> 10 on byte 2, back to 5 on byte 3
      kbase = kerr_cnt;
      send(8'h4B, 1'b0, 5'd5, 2'b10, 8'h46);
      send(8'h6B, 1'b0, 5'd10, 2'b10, 8'h66);
      send(8'h5A, 1'b1, 5'd5, 2'b10, 8'h55);
      drain();
      chk("key_err_once", kerr_cnt - kbase, 1);
      send(8'h4B, 1'b1, 5'd10, 2'b10, 8'h41);
      drain();
      chk("key_err_next_frame", kerr_cnt - kbase, 1);

      // en drops mid-frame
      send(8'h79, 1'b0, 5'd2, 2'b01, 8'h61);
      en = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("en_low_in_ready", {31'h0, in_ready}, 0);
      chk("en_low_drained", {31'h0, v}, 0);
      @(posedge clock); #1;
      en = 1'b1;
      send(8'h41, 1'b1, 5'd2, 2'b01, 8'h43);
      drain();
      chk("en_key_err", kerr_cnt - kbase, 1);

      // reset mid-frame with two bytes buffered
      out_ready = 1'b0;
      send(8'h44, 1'b0, 5'd3, 2'b10, 8'h41);
      send(8'h45, 1'b0, 5'd3, 2'b10, 8'h42);
      #3 rst = 1'b1;
      #1;
      chk("midrst_v", {31'h0, v}, 0);
      chk("midrst_byte_cnt", {16'h0, byte_cnt}, 0);
      chk("midrst_in_ready", {31'h0, in_ready}, 0);
      sb.delete();
      @(posedge clock); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      kbase = kerr_cnt;
      send(8'h48, 1'b1, 5'd7, 2'b10, 8'h41);
      drain();
      chk("postrst_byte_cnt", {16'h0, byte_cnt}, 1);
      chk("postrst_key_err", kerr_cnt - kbase, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
